// File: rtl/softplus_pwl_stream.sv
// Streaming softplus y = ln(1+e^x) on signed Q-format samples: 8-region chord
// approximation in a 3-stage valid/ready pipeline with a per-sample ReLU bypass.
module softplus_pwl_stream #(
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam real SCALE = real'(1 << Q);

  localparam real SP_N4 = 0.018150;
  localparam real SP_N2 = 0.126928;
  localparam real SP_N1 = 0.313262;
  localparam real SP_0  = 0.693147;
  localparam real SP_P1 = 1.313262;
  localparam real SP_P2 = 2.126928;
  localparam real SP_P4 = 4.018150;

  // Chord intercepts (softplus at each region's left breakpoint), rounded to nearest.
  localparam int YA1 = $rtoi(SP_N4 * SCALE + 0.5);
  localparam int YA2 = $rtoi(SP_N2 * SCALE + 0.5);
  localparam int YA3 = $rtoi(SP_N1 * SCALE + 0.5);
  localparam int YA4 = $rtoi(SP_0  * SCALE + 0.5);
  localparam int YA5 = $rtoi(SP_P1 * SCALE + 0.5);
  localparam int YA6 = $rtoi(SP_P2 * SCALE + 0.5);

  // Chord slopes, all in [0,1) so they fit Q+1 unsigned bits.
  localparam int M1 = $rtoi((SP_N2 - SP_N4) / 2.0 * SCALE + 0.5);
  localparam int M2 = $rtoi((SP_N1 - SP_N2) * SCALE + 0.5);
  localparam int M3 = $rtoi((SP_0  - SP_N1) * SCALE + 0.5);
  localparam int M4 = $rtoi((SP_P1 - SP_0 ) * SCALE + 0.5);
  localparam int M5 = $rtoi((SP_P2 - SP_P1) * SCALE + 0.5);
  localparam int M6 = $rtoi((SP_P4 - SP_P2) / 2.0 * SCALE + 0.5);

  localparam logic signed [N-1:0] BP_N4 = N'(-4 * (1 << Q));
  localparam logic signed [N-1:0] BP_N2 = N'(-2 * (1 << Q));
  localparam logic signed [N-1:0] BP_N1 = N'(-1 * (1 << Q));
  localparam logic signed [N-1:0] BP_0  = '0;
  localparam logic signed [N-1:0] BP_P1 = N'(1 << Q);
  localparam logic signed [N-1:0] BP_P2 = N'(2 * (1 << Q));
  localparam logic signed [N-1:0] BP_P4 = N'(4 * (1 << Q));

  localparam logic signed [N+1:0] Y_MAX = (N+2)'((1 << (N-1)) - 1);

  function automatic logic [Q:0] m_lut(input logic [2:0] r);
    case (r)
      3'd1:    m_lut = (Q+1)'(M1);
      3'd2:    m_lut = (Q+1)'(M2);
      3'd3:    m_lut = (Q+1)'(M3);
      3'd4:    m_lut = (Q+1)'(M4);
      3'd5:    m_lut = (Q+1)'(M5);
      3'd6:    m_lut = (Q+1)'(M6);
      default: m_lut = '0;
    endcase
  endfunction

  function automatic logic signed [N+1:0] ya_lut(input logic [2:0] r);
    case (r)
      3'd1:    ya_lut = (N+2)'(YA1);
      3'd2:    ya_lut = (N+2)'(YA2);
      3'd3:    ya_lut = (N+2)'(YA3);
      3'd4:    ya_lut = (N+2)'(YA4);
      3'd5:    ya_lut = (N+2)'(YA5);
      3'd6:    ya_lut = (N+2)'(YA6);
      default: ya_lut = '0;
    endcase
  endfunction

  logic                   advance;
  logic                   v1, v2, v3;
  logic signed [N-1:0]    x1, dx1, x2, p2;
  logic [2:0]             r1, r2;
  logic                   mode1, mode2;
  logic [N-1:0]           d3;

  logic signed [N-1:0]    x_in, dx_in;
  logic [2:0]             region;
  logic signed [N+Q+1:0]  prod;
  logic signed [N-1:0]    p_next;
  logic signed [N+1:0]    y_pre;
  logic [N-1:0]           y_sat;

  assign advance   = !v3 || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3;
  assign out_data  = d3;
  assign busy      = v1 | v2 | v3;
  assign x_in      = $signed(in_data);

  // Stage 1: region select; a breakpoint value lands in the region to its right.
  always_comb begin
    region = 3'd0;
    dx_in  = '0;
    if (x_in < BP_N4) begin
      region = 3'd0;
    end else if (x_in < BP_N2) begin
      region = 3'd1;
      dx_in  = x_in - BP_N4;
    end else if (x_in < BP_N1) begin
      region = 3'd2;
      dx_in  = x_in - BP_N2;
    end else if (x_in < BP_0) begin
      region = 3'd3;
      dx_in  = x_in - BP_N1;
    end else if (x_in < BP_P1) begin
      region = 3'd4;
      dx_in  = x_in - BP_0;
    end else if (x_in < BP_P2) begin
      region = 3'd5;
      dx_in  = x_in - BP_P1;
    end else if (x_in < BP_P4) begin
      region = 3'd6;
      dx_in  = x_in - BP_P2;
    end else begin
      region = 3'd7;
    end
  end

  // Stage 2: dx is non-negative and the slope is below one, so the floored product fits N bits.
  always_comb begin
    prod   = (N+Q+2)'($signed({1'b0, m_lut(r1)})) * (N+Q+2)'(dx1);
    p_next = N'(prod >>> Q);
  end

  // Stage 3: region/mode result, then clamp to the non-negative range.
  always_comb begin
    case (r2)
      3'd0:    y_pre = '0;
      3'd7:    y_pre = (N+2)'(x2);
      default: y_pre = ya_lut(r2) + (N+2)'(p2);
    endcase
    if (mode2) begin
      y_pre = (x2 > 0) ? (N+2)'(x2) : '0;
    end
    if (y_pre < 0) begin
      y_sat = '0;
    end else if (y_pre > Y_MAX) begin
      y_sat = N'(Y_MAX);
    end else begin
      y_sat = N'(y_pre);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      x1    <= '0;
      dx1   <= '0;
      r1    <= '0;
      mode1 <= 1'b0;
      x2    <= '0;
      p2    <= '0;
      r2    <= '0;
      mode2 <= 1'b0;
      d3    <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      if (in_valid) begin
        x1    <= x_in;
        dx1   <= dx_in;
        r1    <= region;
        mode1 <= in_mode;
      end
      v2 <= v1;
      if (v1) begin
        x2    <= x1;
        p2    <= p_next;
        r2    <= r1;
        mode2 <= mode1;
      end
      v3 <= v2;
      if (v2) begin
        d3 <= y_sat;
      end
    end
  end

endmodule

// File: tb/tb_softplus_pwl_stream.sv
// Scoreboard bench for softplus_pwl_stream: a driver pushes expected results on
// accept, an independent monitor pops and compares on every output transfer.
module tb_softplus_pwl_stream;
  localparam int N   = 16;
  localparam int Q   = 12;
  localparam int ONE = 1 << Q;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         in_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_data;
  logic         busy;

  softplus_pwl_stream #(.N(N), .Q(Q)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp;
    int acc;
    bit chk;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   stall_lo = -1;
  int   stall_hi = -2;
  bit   rand_ready = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_data = 0;

  real sp_tab[7] = '{0.018150, 0.126928, 0.313262, 0.693147, 1.313262, 2.126928, 4.018150};
  int  bp_tab[7] = '{-4 * ONE, -2 * ONE, -1 * ONE, 0, ONE, 2 * ONE, 4 * ONE};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    else            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
  end

  function automatic void check_eq(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endfunction

  // Reference: real-valued chord through softplus at the breakpoints, scaled and floored.
  function automatic int model(int x, bit m);
    int y;
    if (m) return (x > 0) ? x : 0;
    if (x < bp_tab[0]) return 0;
    if (x >= bp_tab[6]) return x;
    y = 0;
    for (int i = 0; i < 6; i++) begin
      if (x >= bp_tab[i] && x < bp_tab[i+1]) begin
        int ya = $rtoi(sp_tab[i] * ONE + 0.5);
        int mc = $rtoi((sp_tab[i+1] - sp_tab[i]) * ONE * ONE / real'(bp_tab[i+1] - bp_tab[i]) + 0.5);
        y = ya + (mc * (x - bp_tab[i])) / ONE;
      end
    end
    if (y < 0) y = 0;
    if (y > 32767) y = 32767;
    return y;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [N-1:0] x, input bit m, input int exp, input bit chk);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    #2;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (!in_ready) check_eq("accept_timeout", 0, 1);
    else sb.push_back('{exp, cyc, chk});
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = 1'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || busy) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain_left", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid_hold", int'(out_valid), 1);
        check_eq("stall_data_hold", int'(out_data), prev_data);
      end
      if (out_valid && !out_ready) begin
        check_eq("stall_in_ready", int'(in_ready), 0);
        prev_stall = 1'b1;
        prev_data  = int'(out_data);
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", int'(out_valid), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("out_data", int'(out_data), e.exp);
          if (e.chk) check_eq("latency", cyc - e.acc, 3);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] xr;
    bit           mr;
    logic [N-1:0] stall_x[6] = '{16'hC800, 16'h0400, 16'h2C00, 16'hF000, 16'h5000, 16'h1000};

    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    repeat (2) @(negedge clk);
    check_eq("rst_hold_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    send(16'h0000, 1'b0, 16'h0B17, 1'b1);
    drain();

    send(16'hA000, 1'b0, 16'h0000, 1'b1);
    send(16'hD000, 1'b0, 16'h0129, 1'b1);
    send(16'h1800, 1'b0, 16'h1B85, 1'b1);
    send(16'h4000, 1'b0, 16'h4000, 1'b1);
    drain();

    send(16'hD000, 1'b1, 16'h0000, 1'b1);
    send(16'h1800, 1'b1, 16'h1800, 1'b1);
    drain();

    send(16'h8000, 1'b0, 16'h0000, 1'b1);
    send(16'h7FFF, 1'b0, 16'h7FFF, 1'b1);
    send(16'h1000, 1'b0, 16'h1503, 1'b1);
    send(16'hF000, 1'b0, 1283, 1'b1);
    send(16'hC000, 1'b0, 74, 1'b1);
    drain();

    stall_lo = cyc + 4;
    stall_hi = cyc + 7;
    for (int i = 0; i < 6; i++)
      send(stall_x[i], 1'b0, model(int'($signed(stall_x[i])), 1'b0), 1'b0);
    drain();
    stall_lo = -1;
    stall_hi = -2;

    send(16'h2000, 1'b0, 8712, 1'b0);
    send(16'hE000, 1'b0, 520, 1'b0);
    send(16'h0800, 1'b1, 16'h0800, 1'b0);
    check_eq("inflight_out_valid", int'(out_valid), 1);
    check_eq("inflight_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_busy", int'(busy), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("post_rst_idle", int'(out_valid), 0);
    send(16'h1000, 1'b0, 16'h1503, 1'b1);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      case ($urandom_range(0, 2))
        0:       xr = 16'($urandom);
        1:       xr = 16'(bp_tab[$urandom_range(0, 6)] + int'($urandom_range(0, 8)) - 4);
        default: xr = 16'(int'($urandom_range(0, 10 * ONE)) - 5 * ONE);
      endcase
      mr = ($urandom_range(0, 3) == 0);
      send(xr, mr, model(int'($signed(xr)), mr), 1'b0);
    end
    rand_ready = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/softplus_pwl_stream.md
Name: softplus_pwl_stream

Overview:
- Streaming, parametrised successor to the combinational 16-bit softplus unit.
- Computes y = ln(1+e^x) on signed N-bit fixed-point samples with Q fraction bits, using an 8-region piecewise-linear chord approximation.
- Three-stage pipeline with a valid/ready handshake, plus a per-sample ReLU bypass mode.
- Sits between the VAE encoder's variance-head accumulator and the reparameterisation stage.

Parameters:
- N, 16, total data width in bits; signed two's complement.
- Q, 12, fraction bits; requires N-Q >= 4 so that +/-4.0 is representable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high (already decided). Clears all pipeline state.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts the sample this cycle.
- in_data  in  N  x, signed Q-format.
- in_mode  in  1  0 = softplus, 1 = ReLU bypass; travels with its sample.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  N  y, signed Q-format.
- busy  out  1  any pipeline stage holds a valid sample.

Behaviour:
- Reset: out_valid = 0, out_data = 0, busy = 0, all stage valids = 0, all stage data = 0.
  - in_ready is combinational and equals 1 while rst is held.
  - Asserting rst mid-stream discards every in-flight sample. No output is produced for them.
- Handshake:
  - Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - advance = !v3 || out_ready. in_ready = advance.
  - All three stages shift together when advance = 1. When advance = 0 all stages hold and out_data is stable.
  - Bubbles are not collapsed.
  - Latency is exactly 3 cycles from accept to out_valid when there is no back-pressure.
  - Throughput is 1 sample per cycle.
- Stage 1 (region select). Compare x against breakpoints B = {-4,-2,-1,0,1,2,4}:
  - R0: x < -4.
  - R1..R6: the intervals [-4,-2), [-2,-1), [-1,0), [0,1), [1,2), [2,4).
  - R7: x >= 4.
  - Register x, the region, mode, and dx = x - a, where a is the region's left breakpoint. dx = 0 for R0/R7.
- Stage 2 (multiply):
  - p = m_r * dx, signed full width (N+Q+2 bits).
  - Then arithmetic shift right by Q, i.e. floor.
- Stage 3 (add and saturate):
  - y = ya_r + p for R1..R6. y = 0 for R0. y = x for R7.
  - Mode 1 overrides the region result: y = x if x > 0, else 0.
  - Saturate the result to [0, 2^(N-1)-1]; the result is never negative.
- Coefficients are elaboration-time constants: round-to-nearest of value * 2^Q.
  - ya_r = softplus(a).
  - m_r = (softplus(b) - softplus(a)) / (b - a), where [a,b) is the region.
  - Real values:
    - sp(-4) = 0.018150, sp(-2) = 0.126928, sp(-1) = 0.313262, sp(0) = 0.693147.
    - sp(1) = 1.313262, sp(2) = 2.126928, sp(4) = 4.018150.
- Widths:
  - dx fits in N bits.
  - m_r is unsigned and < 1.0, stored in Q+1 bits.
  - No intermediate overflow is allowed. The only saturation point is stage 3.
- Boundaries:
  - x = -2^(N-1) gives y = 0.
  - x = 2^(N-1)-1 gives y = x.
  - x exactly on a breakpoint selects the region to its right.
- Simultaneous events:
  - Accept and output on the same cycle is legal.
  - When out_ready = 0 with v3 = 1, the input is refused (in_ready = 0) even if earlier stages are empty.
  - in_data and in_mode are ignored when in_valid = 0.
- busy = v1 | v2 | v3.

Test Plan:
- Reset, then drive x = 0x0000 in mode 0 -> out_valid on the 3rd cycle after accept, out_data = 0x0B17 (2839).
- Back-to-back x = 0xA000, 0xD000, 0x1800, 0x4000 in mode 0, out_ready = 1 -> outputs 0x0000, 0x0129, 0x1B85, 0x4000 on consecutive cycles.
- Mode 1 with x = 0xD000 then 0x1800 -> 0x0000 then 0x1800.
- Stream 6 samples with out_ready held low for cycles 4-7 -> in_ready = 0 during the stall, out_data stable, no loss or duplication, order preserved.
- Extremes: x = 0x8000 -> 0x0000; x = 0x7FFF -> 0x7FFF. Breakpoint x = 0x1000 (1.0) -> 0x1503 (5379).
- Assert rst for 1 cycle while 3 samples are in flight -> out_valid and busy drop immediately, nothing emitted afterwards, next sample has normal 3-cycle latency.
